// File: rtl/seq_divider.sv
// Sequential restoring divider: a 2N-bit dividend divided by an N-bit divisor, one quotient bit per clock.
// Uses a start/busy/done handshake. Results are held in registers separate from the working state.
module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] shift_q;   // dividend bits shift out of the MSB, quotient bits enter at the LSB
  logic [N-1:0]   rem_q;
  logic [N-1:0]   dvs_q;
  logic [CW-1:0]  cnt_q;

  logic [N:0]     trial;
  logic [N:0]     diff;
  logic           take;
  logic [N-1:0]   rem_next;
  logic [2*N-1:0] shift_next;

  // A kept partial remainder is always below the divisor, so it fits back into N bits.
  always_comb begin
    trial      = {rem_q, shift_q[2*N-1]};
    diff       = trial - {1'b0, dvs_q};
    take       = (trial >= {1'b0, dvs_q});
    rem_next   = take ? diff[N-1:0] : trial[N-1:0];
    shift_next = {shift_q[2*N-2:0], take};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state   <= RUN;
              shift_q <= dividend;
              rem_q   <= '0;
              dvs_q   <= divisor;
              cnt_q   <= CW'(2 * N);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shift_q <= shift_next;
          rem_q   <= rem_next;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state       <= DONE;
            quotient    <= shift_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): results, latency, busy span, divide-by-zero,
// start-while-busy, back-to-back operation and reset abort.
module tb_seq_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] held_q;   // expected quotient held in the result register during RUN

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    start    = 1'b0;
    dividend = 8'hA5;   // operands are free to change after sampling
    divisor  = 4'h3;
  endtask

  // Called just after the sampling edge; waits for done with a bounded cycle budget.
  task automatic finish(input string tag, input int exp_lat, input int exp_busy,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic [31:0] exp_z);
    int lat       = 0;
    int busy_cnt  = 0;
    int hold_bad  = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (quotient !== held_q[2*N-1:0]) hold_bad++;
      tick();
      lat++;
    end
    check({tag, " done"},      32'(done), 32'd1);
    check({tag, " latency"},   32'(lat), 32'(exp_lat));
    check({tag, " busy_cyc"},  32'(busy_cnt), 32'(exp_busy));
    check({tag, " hold"},      32'(hold_bad), 32'd0);
    check({tag, " quotient"},  32'(quotient), exp_q);
    check({tag, " remainder"}, 32'(remainder), exp_r);
    check({tag, " dbz"},       32'(div_by_zero), exp_z);
    held_q = exp_q;
  endtask

  task automatic divide(input string tag, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                        input logic [31:0] exp_q, input logic [31:0] exp_r);
    launch(dvd, dvs);
    finish(tag, 8, 8, exp_q, exp_r, 32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    held_q   = 32'd0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst q",    32'(quotient), 32'd0);
    check("rst r",    32'(remainder), 32'd0);
    check("rst dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    divide("100/7",  8'd100, 4'd7,  32'd14,  32'd2);
    divide("30/15",  8'd30,  4'd15, 32'd2,   32'd0);
    divide("70/7",   8'd70,  4'd7,  32'd10,  32'd0);
    divide("49/7",   8'd49,  4'd7,  32'd7,   32'd0);
    divide("120/12", 8'd120, 4'd12, 32'd10,  32'd0);
    divide("255/1",  8'd255, 4'd1,  32'd255, 32'd0);
    divide("255/15", 8'd255, 4'd15, 32'd17,  32'd0);
    divide("0/9",    8'd0,   4'd9,  32'd0,   32'd0);
    divide("14/15",  8'd14,  4'd15, 32'd0,   32'd14);

    // Divide-by-zero goes straight to DONE on the sampling edge.
    launch(8'd77, 4'd0);
    finish("77/0", 0, 0, 32'd255, 32'd0, 32'd1);
    tick();
    check("77/0 done_pulse", 32'(done), 32'd0);
    divide("20/3", 8'd20, 4'd3, 32'd6, 32'd2);

    // start held high with new operands through the whole RUN is ignored.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd9;
    tick();
    dividend = 8'd50;
    divisor  = 4'd3;
    for (int i = 0; i < 7; i++) begin
      check("held start busy", 32'(busy), 32'd1);
      tick();
    end
    check("held start busy last", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    check("held start done",      32'(done), 32'd1);
    check("held start quotient",  32'(quotient), 32'd22);
    check("held start remainder", 32'(remainder), 32'd2);
    held_q = 32'd22;
    tick();

    // Back-to-back: second start in the done cycle; first result held through RUN.
    divide("45/4 pre", 8'd45, 4'd4, 32'd11, 32'd1);
    launch(8'd45, 4'd4);
    finish("45/4", 8, 8, 32'd11, 32'd1, 32'd0);
    launch(8'd99, 4'd5);
    check("b2b busy", 32'(busy), 32'd1);
    finish("99/5", 8, 8, 32'd19, 32'd4, 32'd0);
    tick();

    // Reset asserted during the 4th RUN cycle aborts with no done pulse.
    launch(8'd100, 4'd7);
    tick();
    tick();
    tick();
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort q",    32'(quotient), 32'd0);
    check("abort r",    32'(remainder), 32'd0);
    check("abort dbz",  32'(div_by_zero), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("abort quiet", 32'(done_seen), 32'd0);
    held_q = 32'd0;
    divide("100/7 again", 8'd100, 4'd7, 32'd14, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
